pipeline_stall_controller: RTL and testbench

//   Central freeze/flush sequencer for the 5-stage MIPS pipeline.

---
 rtl/pipeline_stall_controller.sv | 74 +++++++
 tb/tb_pipeline_stall_controller.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: freeze/flush/bubble sequencer for the 5-stage pipeline
// with a MEM wait-state watchdog and saturating stall/flush counters.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             perf_clear,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_exe_bubble,
    output logic             back_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WT_W = $clog2(MEM_TIMEOUT + 1) > 8 ? $clog2(MEM_TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t          state, state_nx;
    logic [WT_W-1:0] wt, wt_nx;
    logic            mem_stall, stall_inc;

    always_comb begin
        state_nx = state;
        wt_nx    = wt;
        case (state)
            RUN:      if (mem_req && !mem_ready) begin
                          state_nx = MEM_WAIT;
                          wt_nx    = WT_W'(1);
                      end
            MEM_WAIT: if (mem_ready) begin
                          state_nx = RUN;
                          wt_nx    = '0;
                      end else begin
                          wt_nx    = wt + WT_W'(1);
                          state_nx = (wt == WT_W'(MEM_TIMEOUT)) ? ERROR : MEM_WAIT;
                      end
            default:  ;
        endcase
    end

    // priority: memory stall > taken branch > ID hazard
    assign mem_stall     = (state == RUN && mem_req && !mem_ready) ||
                           (state == MEM_WAIT && !mem_ready) || state == ERROR;
    assign pc_freeze     = mem_stall || (!branch_taken && hazard_detected);
    assign if_id_freeze  = pc_freeze;
    assign if_id_flush   = !mem_stall && branch_taken;
    assign id_exe_bubble = !mem_stall && (branch_taken || hazard_detected);
    assign back_freeze   = mem_stall;
    assign mem_timeout   = state == ERROR;
    assign stall_inc     = (pc_freeze || back_freeze || id_exe_bubble) && !if_id_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wt        <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nx;
            wt        <= wt_nx;
            stall_cnt <= perf_clear ? '0 : (stall_inc && !(&stall_cnt)) ? stall_cnt + CNT_W'(1) : stall_cnt;
            flush_cnt <= perf_clear ? '0 : (if_id_flush && !(&flush_cnt)) ? flush_cnt + CNT_W'(1) : flush_cnt;
        end
    end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed vector table plus hand sequences for
// watchdog timeout, async reset out of ERROR and counter saturation.
module tb_pipeline_stall_controller;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             hazard_detected = 1'b0, branch_taken = 1'b0, mem_req = 1'b0;
    logic             mem_ready = 1'b0, perf_clear = 1'b0;
    logic             pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, back_freeze, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .perf_clear(perf_clear),
        .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
        .id_exe_bubble(id_exe_bubble), .back_freeze(back_freeze), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, back_freeze, mem_timeout}
    typedef struct {
        logic [4:0] in;   // {hazard, branch, mem_req, mem_ready, perf_clear}
        logic [5:0] ctl;
        int         sc;
        int         fc;
    } vec_t;

    vec_t tbl[20];

    function automatic logic [5:0] ctl_now();
        return {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, back_freeze, mem_timeout};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] v);
        @(negedge clk);
        {hazard_detected, branch_taken, mem_req, mem_ready, perf_clear} = v;
        #1;
    endtask

    initial begin
        tbl[0]  = '{5'b00000, 6'b000000, 0, 0};
        tbl[1]  = '{5'b10000, 6'b110100, 0, 0};  // hazard
        tbl[2]  = '{5'b00000, 6'b000000, 1, 0};
        tbl[3]  = '{5'b00100, 6'b110010, 1, 0};  // RUN miss -> MEM_WAIT
        tbl[4]  = '{5'b00100, 6'b110010, 2, 0};
        tbl[5]  = '{5'b00100, 6'b110010, 3, 0};
        tbl[6]  = '{5'b00110, 6'b000000, 4, 0};  // ready: freeze drops
        tbl[7]  = '{5'b00000, 6'b000000, 4, 0};
        tbl[8]  = '{5'b11000, 6'b001100, 4, 0};  // branch beats hazard
        tbl[9]  = '{5'b00000, 6'b000000, 4, 1};
        tbl[10] = '{5'b00010, 6'b000000, 4, 1};  // ready without req
        tbl[11] = '{5'b00110, 6'b000000, 4, 1};  // zero-wait access
        tbl[12] = '{5'b00000, 6'b000000, 4, 1};
        tbl[13] = '{5'b01100, 6'b110010, 4, 1};  // branch held during miss
        tbl[14] = '{5'b01100, 6'b110010, 5, 1};
        tbl[15] = '{5'b01110, 6'b001100, 6, 1};  // flush on ready cycle
        tbl[16] = '{5'b00001, 6'b000000, 6, 2};
        tbl[17] = '{5'b00000, 6'b000000, 0, 0};
        tbl[18] = '{5'b10001, 6'b110100, 0, 0};  // clear beats increment
        tbl[19] = '{5'b00000, 6'b000000, 0, 0};

        #1;
        chk("reset_ctl", int'(ctl_now()), 0);
        chk("reset_cnt", int'({stall_cnt, flush_cnt}), 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            chk($sformatf("vec%0d_ctl", i), int'(ctl_now()), int'(tbl[i].ctl));
            chk($sformatf("vec%0d_stall", i), int'(stall_cnt), tbl[i].sc);
            chk($sformatf("vec%0d_flush", i), int'(flush_cnt), tbl[i].fc);
        end

        // watchdog: one RUN miss cycle, then MEM_WAIT wt=1..4, then ERROR
        drive(5'b00100);
        chk("to_run_ctl", int'(ctl_now()), int'(6'b110010));
        for (int k = 1; k <= 4; k++) begin
            drive(5'b00100);
            chk($sformatf("to_wait%0d_ctl", k), int'(ctl_now()), int'(6'b110010));
        end
        drive(5'b00100);
        chk("to_error_ctl", int'(ctl_now()), int'(6'b110011));
        chk("to_error_stall", int'(stall_cnt), 5);
        drive(5'b11010);
        chk("error_sticky_ctl", int'(ctl_now()), int'(6'b110011));
        drive(5'b00000);
        chk("error_idle_ctl", int'(ctl_now()), int'(6'b110011));
        chk("error_flush", int'(flush_cnt), 0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_ctl", int'(ctl_now()), 0);
        chk("async_rst_cnt", int'({stall_cnt, flush_cnt}), 0);
        @(negedge clk);
        rst = 1'b1;
        drive(5'b00000);
        chk("post_rst_run", int'(ctl_now()), 0);

        // saturation: hazard held 20 cycles
        for (int k = 0; k < 20; k++) drive(5'b10000);
        chk("sat_ctl", int'(ctl_now()), int'(6'b110100));
        drive(5'b00001);
        chk("sat_stall", int'(stall_cnt), 15);
        drive(5'b00000);
        chk("clear_stall", int'(stall_cnt), 0);

        // flush counter saturation
        for (int k = 0; k < 17; k++) drive(5'b01000);
        drive(5'b00000);
        chk("sat_flush", int'(flush_cnt), 15);
        chk("sat_flush_stall", int'(stall_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
